// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB plus an interrupt entry state.
// Strobes are decoded from the registered state and the opcode/funct captured at fetch.
module multicycle_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ins,
   input  logic        zero,
   input  logic        mem_ready,
   input  logic        int_req,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        ir_we,
   output logic        reg_dst,
   output logic        reg_write,
   output logic        alu_src,
   output logic        mem_read,
   output logic        mem_write,
   output logic        mem2reg,
   output logic [2:0]  alu_op,
   output logic [2:0]  state,
   output logic [15:0] retired,
   output logic        illegal
);

   // state | meaning
   // 0 FETCH  | load IR, or divert to INT when an interrupt is pending
   // 1 DECODE | dispatch on captured opcode; j and illegal opcodes finish here
   // 2 EXEC   | ALU operation; beq resolves here
   // 3 MEM    | data access, held until mem_ready
   // 4 WB     | register write-back
   // 5 INT    | jump to the interrupt entry point
   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_INT    = 3'd5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   logic [2:0]  state_q, state_d;
   logic [5:0]  op_q, funct_q;
   logic        int_pending;
   logic        illegal_q;
   logic        illegal_now;
   logic [15:0] retired_q;
   logic        is_r, is_addi, is_lw, is_sw, is_beq, is_j, is_exec_op;
   logic [2:0]  exec_alu_op;
   logic        unused_ins;

   // Only opcode and funct fields are of interest to the control path.
   assign unused_ins = ^ins[25:6];

   assign is_r       = (op_q == OP_RTYPE);
   assign is_addi    = (op_q == OP_ADDI);
   assign is_lw      = (op_q == OP_LW);
   assign is_sw      = (op_q == OP_SW);
   assign is_beq     = (op_q == OP_BEQ);
   assign is_j       = (op_q == OP_J);
   assign is_exec_op = is_r | is_addi | is_lw | is_sw | is_beq;

   always_comb begin
      exec_alu_op = ALU_ADD;
      if (is_beq) begin
         exec_alu_op = ALU_SUB;
      end else if (is_r) begin
         case (funct_q)
            6'h22:   exec_alu_op = ALU_SUB;
            6'h24:   exec_alu_op = ALU_AND;
            6'h25:   exec_alu_op = ALU_OR;
            6'h2A:   exec_alu_op = ALU_SLT;
            default: exec_alu_op = ALU_ADD;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = int_pending ? S_INT : S_DECODE;
         S_DECODE: state_d = is_exec_op ? S_EXEC : S_FETCH;
         S_EXEC: begin
            if (is_r || is_addi)     state_d = S_WB;
            else if (is_lw || is_sw) state_d = S_MEM;
            else                     state_d = S_FETCH;
         end
         S_MEM: begin
            if (!mem_ready) state_d = S_MEM;
            else if (is_lw) state_d = S_WB;
            else            state_d = S_FETCH;
         end
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pc_we       = 1'b0;
      pc_sel      = 2'd0;
      ir_we       = 1'b0;
      reg_dst     = 1'b0;
      reg_write   = 1'b0;
      alu_src     = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem2reg     = 1'b0;
      alu_op      = 3'b000;
      illegal_now = 1'b0;
      case (state_q)
         S_FETCH: ir_we = !int_pending;
         S_DECODE: begin
            if (is_j) begin
               pc_we  = 1'b1;
               pc_sel = 2'd2;
            end else if (!is_exec_op) begin
               pc_we       = 1'b1;
               illegal_now = 1'b1;
            end
         end
         S_EXEC: begin
            alu_src = is_addi | is_lw | is_sw;
            alu_op  = exec_alu_op;
            if (is_beq) begin
               pc_we  = 1'b1;
               pc_sel = zero ? 2'd1 : 2'd0;
            end
         end
         S_MEM: begin
            mem_read  = is_lw;
            mem_write = is_sw;
            alu_src   = 1'b1;
            alu_op    = ALU_ADD;
            pc_we     = mem_ready & is_sw;
         end
         S_WB: begin
            reg_write = 1'b1;
            reg_dst   = is_r;
            mem2reg   = is_lw;
            alu_src   = is_addi | is_lw;
            alu_op    = exec_alu_op;
            pc_we     = 1'b1;
         end
         S_INT: begin
            pc_we  = 1'b1;
            pc_sel = 2'd3;
         end
         default: ;
      endcase
   end

   // Capture happens only on a real fetch, so an interrupt leaves the last opcode intact.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q        <= 6'd0;
         funct_q     <= 6'd0;
         int_pending <= 1'b0;
         illegal_q   <= 1'b0;
         retired_q   <= 16'd0;
      end else begin
         if (ir_we) begin
            op_q    <= ins[31:26];
            funct_q <= ins[5:0];
         end
         if (int_req)                int_pending <= 1'b1;
         else if (state_q == S_INT)  int_pending <= 1'b0;
         if (illegal_now)            illegal_q   <= 1'b1;
         if (pc_we && state_q != S_INT) retired_q <= retired_q + 16'd1;
      end
   end

   assign state   = state_q;
   assign retired = retired_q;
   assign illegal = illegal_q | illegal_now;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: the driver queues the expected per-cycle
// control vector, and a negedge monitor pops and compares it against the outputs.
module tb_multicycle_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ins;
   logic        zero, mem_ready, int_req;
   logic        pc_we, ir_we, reg_dst, reg_write, alu_src, mem_read, mem_write, mem2reg;
   logic [1:0]  pc_sel;
   logic [2:0]  alu_op, state;
   logic [15:0] retired;
   logic        illegal;

   multicycle_sequencer dut (
      .clk(clk), .rst(rst), .ins(ins), .zero(zero), .mem_ready(mem_ready),
      .int_req(int_req), .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we),
      .reg_dst(reg_dst), .reg_write(reg_write), .alu_src(alu_src),
      .mem_read(mem_read), .mem_write(mem_write), .mem2reg(mem2reg),
      .alu_op(alu_op), .state(state), .retired(retired), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic [2:0]  st;
      logic [12:0] ctl;
      logic        ill;
      logic [15:0] ret;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] ret_m    = 16'd0;
   logic        ill_m    = 1'b0;

   // Control vector: {pc_we, pc_sel, ir_we, reg_dst, reg_write, alu_src, mem_read, mem_write, mem2reg, alu_op}
   function automatic logic [12:0] c(input logic pw, input logic [1:0] ps, input logic iw,
                                     input logic rd, input logic rw, input logic as,
                                     input logic mr, input logic mw, input logic m2r,
                                     input logic [2:0] ao);
      return {pw, ps, iw, rd, rw, as, mr, mw, m2r, ao};
   endfunction

   localparam logic [12:0] C_FETCH = 13'b0_00_1_000000_000;
   localparam logic [12:0] C_NONE  = 13'd0;

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         logic [12:0] act;
         e   = exp_q.pop_front();
         act = {pc_we, pc_sel, ir_we, reg_dst, reg_write, alu_src, mem_read, mem_write, mem2reg, alu_op};
         n_checks++;
         if (state !== e.st || act !== e.ctl || illegal !== e.ill || retired !== e.ret) begin
            n_fail++;
            $display("FAIL %s: got state=%0d ctl=%h ill=%b ret=%h, expected state=%0d ctl=%h ill=%b ret=%h",
                     e.nm, state, act, illegal, retired, e.st, e.ctl, e.ill, e.ret);
         end
      end
   end

   // Queue this cycle's expectation, then advance one clock.
   task automatic step(input string nm, input logic [2:0] st, input logic [12:0] ctl);
      exp_t e;
      e.nm = nm; e.st = st; e.ctl = ctl; e.ill = ill_m; e.ret = ret_m;
      exp_q.push_back(e);
      if (ctl[12] && st != 3'd5) ret_m = ret_m + 16'd1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_rtype(input string nm, input logic [31:0] w, input logic [2:0] ao);
      ins = w;
      step({nm, "_fetch"}, 3'd0, C_FETCH);
      ins = '1;
      step({nm, "_decode"}, 3'd1, C_NONE);
      step({nm, "_exec"}, 3'd2, c(0, 0, 0, 0, 0, 0, 0, 0, 0, ao));
      step({nm, "_wb"}, 3'd4, c(1, 0, 0, 1, 1, 0, 0, 0, 0, ao));
   endtask

   localparam logic [31:0] I_ADD  = 32'h012A4020;
   localparam logic [31:0] I_ADDI = 32'h21080005;
   localparam logic [31:0] I_LW   = 32'h8C880004;
   localparam logic [31:0] I_SW   = 32'hAC880004;
   localparam logic [31:0] I_BEQ  = 32'h11090002;
   localparam logic [31:0] I_J    = 32'h08000010;
   localparam logic [31:0] I_ILL  = 32'hFC000000;

   initial begin
      rst = 1'b1; ins = 32'd0; zero = 1'b0; mem_ready = 1'b1; int_req = 1'b0;
      @(posedge clk);
      #1;
      step("reset", 3'd0, C_FETCH);
      rst = 1'b0;

      run_rtype("add", I_ADD, 3'b010);
      run_rtype("sub", 32'h01094022, 3'b110);
      run_rtype("and", 32'h01094024, 3'b000);
      run_rtype("or",  32'h01094025, 3'b001);
      run_rtype("slt", 32'h0109402A, 3'b111);
      run_rtype("fdef", 32'h0109403F, 3'b010);

      ins = I_ADDI;
      step("addi_fetch", 3'd0, C_FETCH);
      ins = '1;
      step("addi_decode", 3'd1, C_NONE);
      step("addi_exec", 3'd2, c(0, 0, 0, 0, 0, 1, 0, 0, 0, 3'b010));
      step("addi_wb", 3'd4, c(1, 0, 0, 0, 1, 1, 0, 0, 0, 3'b010));

      ins = I_LW;
      step("lw_fetch", 3'd0, C_FETCH);
      ins = '1;
      step("lw_decode", 3'd1, C_NONE);
      step("lw_exec", 3'd2, c(0, 0, 0, 0, 0, 1, 0, 0, 0, 3'b010));
      mem_ready = 1'b0;
      step("lw_mem1", 3'd3, c(0, 0, 0, 0, 0, 1, 1, 0, 0, 3'b010));
      step("lw_mem2", 3'd3, c(0, 0, 0, 0, 0, 1, 1, 0, 0, 3'b010));
      mem_ready = 1'b1;
      step("lw_mem3", 3'd3, c(0, 0, 0, 0, 0, 1, 1, 0, 0, 3'b010));
      step("lw_wb", 3'd4, c(1, 0, 0, 0, 1, 1, 0, 0, 1, 3'b010));

      ins = I_SW;
      step("sw_fetch", 3'd0, C_FETCH);
      ins = '1;
      step("sw_decode", 3'd1, C_NONE);
      step("sw_exec", 3'd2, c(0, 0, 0, 0, 0, 1, 0, 0, 0, 3'b010));
      step("sw_mem", 3'd3, c(1, 0, 0, 0, 0, 1, 0, 1, 0, 3'b010));

      for (int z = 1; z >= 0; z--) begin
         ins = I_BEQ;
         step("beq_fetch", 3'd0, C_FETCH);
         ins = '1;
         step("beq_decode", 3'd1, C_NONE);
         zero = z[0];
         step(z ? "beq_exec_z1" : "beq_exec_z0", 3'd2, c(1, z ? 2'd1 : 2'd0, 0, 0, 0, 0, 0, 0, 0, 3'b110));
         zero = 1'b0;
      end

      ins = I_J;
      step("j_fetch", 3'd0, C_FETCH);
      ins = '1;
      step("j_decode", 3'd1, c(1, 2, 0, 0, 0, 0, 0, 0, 0, 3'b000));

      ins = I_ADD;
      step("irq_add_fetch", 3'd0, C_FETCH);
      ins = '1;
      step("irq_add_decode", 3'd1, C_NONE);
      int_req = 1'b1;
      step("irq_add_exec", 3'd2, c(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010));
      int_req = 1'b0;
      step("irq_add_wb", 3'd4, c(1, 0, 0, 1, 1, 0, 0, 0, 0, 3'b010));
      ins = I_J;
      step("irq_fetch_blocked", 3'd0, C_NONE);
      step("irq_int", 3'd5, c(1, 3, 0, 0, 0, 0, 0, 0, 0, 3'b000));
      step("irq_refetch", 3'd0, C_FETCH);
      step("irq_j_decode", 3'd1, c(1, 2, 0, 0, 0, 0, 0, 0, 0, 3'b000));

      ins = I_ILL;
      step("ill_fetch", 3'd0, C_FETCH);
      ins = 32'd0;
      ill_m = 1'b1;
      step("ill_decode", 3'd1, c(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
      ins = I_LW;
      step("ill_sticky_fetch", 3'd0, C_FETCH);
      ins = '1;
      step("rlw_decode", 3'd1, C_NONE);
      step("rlw_exec", 3'd2, c(0, 0, 0, 0, 0, 1, 0, 0, 0, 3'b010));
      mem_ready = 1'b0;
      step("rlw_mem", 3'd3, c(0, 0, 0, 0, 0, 1, 1, 0, 0, 3'b010));
      rst = 1'b1;
      ill_m = 1'b0;
      ret_m = 16'd0;
      step("rst_in_mem", 3'd0, C_FETCH);
      step("rst_held", 3'd0, C_FETCH);
      rst = 1'b0;
      mem_ready = 1'b1;

      ins = I_J;
      for (int k = 0; k < 65535; k++) begin
         @(posedge clk);
         #1;
         @(posedge clk);
         #1;
      end
      ret_m = 16'hFFFF;
      step("wrap_fetch", 3'd0, C_FETCH);
      step("wrap_decode", 3'd1, c(1, 2, 0, 0, 0, 0, 0, 0, 0, 3'b000));
      step("wrap_after", 3'd0, C_FETCH);

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
